a_vector_source: RTL and testbench

- Upstream stage that feeds module a's three offset-range vector inputs: vector0 [1:1], vector1 [8:1], vector2 [20:5].
- Accepts a 16-bit word stream with packet delimiting over a valid/ready handshake.
- Tags each word with its 1-based index within the packet and a last-word flag.
- Buffers up to DEPTH words and presents them on offset-range output ports with a valid/ready handshake.

---
 rtl/a_vector_source.sv | 126 ++++++++++++
 tb/tb_a_vector_source.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/a_vector_source.sv
// a_vector_source: upstream feeder for module a's offset-range vector inputs.
// Accepts a 16-bit word stream with packet delimiting (valid/ready). Each word is
// tagged with its 1-based index within the packet and a last-word flag, then buffered
// (output register + (DEPTH-1)-entry circular FIFO) and presented on vector0/1/2.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready is combinational
//   in_data, in_last    word payload and end-of-packet flag
//   out_valid/out_ready downstream handshake
//   vector0 [1:1]       last-word flag of the presented entry
//   vector1 [8:1]       1-based word index within the packet
//   vector2 [20:5]      payload, vector2[5] = in_data[0]
module a_vector_source #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:1]  vector0,
  output logic [8:1]  vector1,
  output logic [20:5] vector2
);

  localparam int unsigned FifoDepth = DEPTH - 1;
  localparam int unsigned PtrW      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW      = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(FifoDepth - 1);
  localparam logic [CntW-1:0] OccMax  = CntW'(DEPTH);

  // Entry layout: {last, index[7:0], data[15:0]}
  logic [24:0]     mem_q [FifoDepth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] fcnt_q, fcnt_d, occ_q, occ_d;
  logic [7:0]      idx_q, idx_d;
  logic [24:0]     out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            accept, pop, fifo_push, fifo_pop;
  logic [24:0]     in_entry;

  // No pass-through: a pop in the same cycle does not open in_ready when full.
  assign in_ready = !rst && (occ_q < OccMax);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;
  assign in_entry = {in_last, idx_q, in_data};

  // Output register load selection. The FIFO is only ever non-empty while the
  // output register holds a valid entry, so an empty register loads straight from input.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    if (!out_valid_q) begin
      if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end
    end else if (pop) begin
      if (fcnt_q != '0) begin
        out_d     = mem_q[rptr_q];
        fifo_pop  = 1'b1;
        fifo_push = accept;
      end else if (accept) begin
        out_d = in_entry;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      fifo_push = accept;
    end
  end

  // Pointers wrap modulo DEPTH-1, which need not be a power of two.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    occ_d  = occ_q;
    idx_d  = idx_q;
    if (fifo_push) wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
    if (fifo_pop)  rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
    if (fifo_push && !fifo_pop)      fcnt_d = fcnt_q + 1'b1;
    else if (!fifo_push && fifo_pop) fcnt_d = fcnt_q - 1'b1;
    if (accept && !pop)      occ_d = occ_q + 1'b1;
    else if (!accept && pop) occ_d = occ_q - 1'b1;
    // Index skips 0: 255 wraps to 1, and in_last restarts the next packet at 1.
    if (accept) idx_d = (in_last || (idx_q == 8'd255)) ? 8'd1 : idx_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
      occ_q       <= '0;
      idx_q       <= 8'd1;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
      occ_q       <= occ_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage array needs no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wptr_q] <= in_entry;
  end

  assign out_valid = out_valid_q;
  assign vector0   = out_q[24];
  assign vector1   = out_q[23:16];
  assign vector2   = out_q[15:0];

endmodule

// File: tb/tb_a_vector_source.sv
module tb_a_vector_source;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [1:1]  vector0;
  logic [8:1]  vector1;
  logic [20:5] vector2;

  a_vector_source #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .vector0  (vector0),
    .vector1  (vector1),
    .vector2  (vector2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the whole block is a bounded queue of tagged words.
  logic [24:0] mq[$];
  logic [24:0] last_pop;
  logic [7:0]  midx;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last_pop = '0;
    midx     = 8'd1;
  endtask

  task automatic chk_out(input string tag);
    logic [24:0] e;
    e = (mq.size() != 0) ? mq[0] : last_pop;
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk({tag, "_vec"}, {7'd0, vector0, vector1, vector2}, {7'd0, e});
  endtask

  // Called at posedge+1; drives inputs for the coming edge and checks after it.
  task automatic tick(input logic v, input logic [15:0] d, input logic l, input logic r);
    logic acc, pp;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < DEPTH});
    acc = v && (mq.size() < DEPTH);
    pp  = r && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (pp) last_pop = mq.pop_front();
    if (acc) begin
      mq.push_back({l, midx, d});
      midx = (l || midx == 8'd255) ? 8'd1 : midx + 8'd1;
    end
    chk_out("out");
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_vec"}, {7'd0, vector0, vector1, vector2}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset and idle; release between edges
    #12;
    chk_reset_state("reset");
    #10;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    tick(1'b0, 16'h0, 1'b0, 1'b1);

    // Single packet with out_ready=1, each word visible one cycle after accept
    tick(1'b1, 16'h1234, 1'b0, 1'b1);
    chk("pkt_w1", {7'd0, vector0, vector1, vector2}, {7'd0, 1'b0, 8'd1, 16'h1234});
    tick(1'b1, 16'hABCD, 1'b0, 1'b1);
    chk("pkt_w2", {7'd0, vector0, vector1, vector2}, {7'd0, 1'b0, 8'd2, 16'hABCD});
    tick(1'b1, 16'hFFFF, 1'b1, 1'b1);
    chk("pkt_w3", {7'd0, vector0, vector1, vector2}, {7'd0, 1'b1, 8'd3, 16'hFFFF});
    tick(1'b1, 16'h5555, 1'b0, 1'b1);
    chk("pkt2_idx", {24'd0, vector1}, 32'd1);
    tick(1'b0, 16'h0, 1'b0, 1'b1);

    // Backpressure to full, then drain
    for (int i = 0; i < 6; i++) tick(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b0, 16'h0, 1'b0, 1'b1);

    // Simultaneous accept and pop at occupancy 1 and 3
    tick(1'b1, 16'h1111, 1'b0, 1'b0);
    tick(1'b1, 16'h2222, 1'b0, 1'b1);
    tick(1'b1, 16'h3333, 1'b0, 1'b1);
    tick(1'b1, 16'h4444, 1'b0, 1'b0);
    tick(1'b1, 16'h5555, 1'b0, 1'b0);
    tick(1'b1, 16'h6666, 1'b0, 1'b1);
    tick(1'b1, 16'h7777, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0, 1'b0, 1'b1);

    // Index wrap across a 257-word packet
    for (int i = 1; i <= 257; i++) begin
      tick(1'b1, 16'(i), (i == 257), 1'b1);
      if (i == 255) chk("wrap_255", {24'd0, vector1}, 32'd255);
      if (i == 256) chk("wrap_256", {24'd0, vector1}, 32'd1);
      if (i == 257) chk("wrap_257", {24'd0, vector1}, 32'd2);
      chk("wrap_last", {31'd0, vector0}, {31'd0, i == 257});
    end
    tick(1'b0, 16'h0, 1'b0, 1'b1);

    // Reset mid-packet with 2 words buffered
    for (int i = 0; i < 3; i++) tick(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b1);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    tick(1'b1, 16'hC003, 1'b0, 1'b0);
    tick(1'b1, 16'hC004, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    model_reset();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    tick(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("post_rst_idx", {24'd0, vector1}, 32'd1);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 7) == 0),
           (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 16'h0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
